// File: rtl/cam_capture_rgb444.sv
// cam_capture_rgb444: OV7670 RGB444 byte-pair packer driving a frame buffer write port.
// Frames start on VSYNC fall and end on VSYNC rise; pixels are stored linearly from address 0.
module cam_capture_rgb444 #(
    parameter int AW    = 15,
    parameter int DW    = 12,
    parameter int IMG_W = 160,
    parameter int IMG_H = 120
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          capture_en,
    input  logic          vsync,
    input  logic          href,
    input  logic [7:0]    px_data,
    output logic [AW-1:0] addr_in,
    output logic [DW-1:0] data_in,
    output logic          regwrite,
    output logic          frame_done,
    output logic          busy
);
    localparam int CW = $clog2(IMG_W + 1);
    localparam logic [AW:0]   NPIX = (AW+1)'(IMG_W * IMG_H);
    localparam logic [CW-1:0] WMAX = CW'(IMG_W);
    typedef enum logic [1:0] {WAIT_VS, ARM, CAPTURE} state_t;
    state_t        state;
    logic          vsync_q, href_q, phase;
    logic [3:0]    red;
    logic [AW:0]   pix_cnt;
    logic [CW-1:0] col_cnt;
    logic          vs_rise, vs_fall, href_fall, pix_ok;
    assign vs_rise   = vsync & ~vsync_q;
    assign vs_fall   = ~vsync & vsync_q;
    assign href_fall = ~href & href_q;
    // Extra pixels on a line and anything past the last buffer word are dropped.
    assign pix_ok    = (col_cnt < WMAX) && (pix_cnt < NPIX);
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= WAIT_VS;
            vsync_q    <= 1'b0;
            href_q     <= 1'b0;
            phase      <= 1'b0;
            red        <= '0;
            pix_cnt    <= '0;
            col_cnt    <= '0;
            addr_in    <= '0;
            data_in    <= '0;
            regwrite   <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            vsync_q    <= vsync;
            href_q     <= href;
            regwrite   <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                WAIT_VS: if (vs_rise) state <= ARM;
                ARM: if (vs_fall) begin
                    state   <= capture_en ? CAPTURE : WAIT_VS;
                    busy    <= capture_en;
                    pix_cnt <= '0;
                    col_cnt <= '0;
                    phase   <= 1'b0;
                end
                CAPTURE: if (vs_rise) begin
                    state      <= ARM;
                    busy       <= 1'b0;
                    frame_done <= (pix_cnt == NPIX);
                end else if (href) begin
                    phase <= ~phase;
                    if (!phase) red <= px_data[3:0];
                    else if (pix_ok) begin
                        addr_in  <= pix_cnt[AW-1:0];
                        data_in  <= DW'({red, px_data});
                        regwrite <= 1'b1;
                        pix_cnt  <= pix_cnt + 1'b1;
                        col_cnt  <= col_cnt + 1'b1;
                    end
                end else if (href_fall) begin
                    phase   <= 1'b0;
                    col_cnt <= '0;
                end
                default: state <= WAIT_VS;
            endcase
        end
    end
endmodule

// File: tb/tb_cam_capture_rgb444.sv
// tb_cam_capture_rgb444: randomized frames against a line/pixel list model with a write scoreboard.
module tb_cam_capture_rgb444;
    localparam int AW = 4, DW = 12, IMG_W = 4, IMG_H = 3, NPIX = IMG_W * IMG_H;
    logic clk = 0, reset = 1, capture_en = 0, vsync = 0, href = 0;
    logic [7:0] px_data = 0;
    logic [AW-1:0] addr_in;
    logic [DW-1:0] data_in;
    logic regwrite, frame_done, busy;
    int compared = 0, mismatched = 0, fd_exp = 0;
    logic [AW+DW-1:0] exp_q[$];
    logic [7:0] bytes [8][16];
    int lens[$];

    cam_capture_rgb444 #(.AW(AW), .DW(DW), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .clk(clk), .reset(reset), .capture_en(capture_en), .vsync(vsync), .href(href),
        .px_data(px_data), .addr_in(addr_in), .data_in(data_in), .regwrite(regwrite),
        .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every strobe must match the next expected write, every done pulse an expected frame.
    always @(negedge clk) begin
        if (regwrite) begin
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL write_unexpected: got addr %0h data %0h expected none", addr_in, data_in);
            end else begin
                logic [AW+DW-1:0] e;
                e = exp_q.pop_front();
                if ({addr_in, data_in} !== e) begin
                    mismatched++;
                    $display("FAIL write: got addr %0h data %0h expected addr %0h data %0h",
                             addr_in, data_in, e[AW+DW-1:DW], e[DW-1:0]);
                end
            end
        end
        if (frame_done) begin
            compared++;
            if (fd_exp == 0) begin
                mismatched++;
                $display("FAIL frame_done_unexpected: got 1 expected 0");
            end else fd_exp--;
        end
    end

    task automatic drive_frame(input bit en, input bit flip, input int rst_after, input bit fixed);
        int total = 0;
        foreach (lens[l])
            for (int i = 0; i < lens[l]; i++)
                bytes[l][i] = fixed ? ((i % 2) ? 8'hBC : 8'h0A) : 8'($urandom);
        if (en)
            foreach (lens[l])
                if (rst_after < 0 || l < rst_after)
                    for (int p = 0; p < lens[l] / 2 && p < IMG_W; p++)
                        if (total < NPIX) begin
                            exp_q.push_back({AW'(total), bytes[l][2*p][3:0], bytes[l][2*p+1]});
                            total++;
                        end
        if (en && rst_after < 0 && total == NPIX) fd_exp++;
        // VSYNC high with HREF also high: bytes must be ignored.
        capture_en = en;
        vsync = 1;
        href = 1;
        px_data = 8'h55;
        repeat (3) @(negedge clk);
        href = 0;
        repeat (2) @(negedge clk);
        vsync = 0;
        repeat (2) @(negedge clk);
        chk("busy_frame", busy, en);
        foreach (lens[l]) begin
            if (l == rst_after) begin
                reset = 1;
                @(negedge clk);
                reset = 0;
                chk("rst_addr", addr_in, 0);
                chk("rst_data", data_in, 0);
                chk("rst_regwrite", regwrite, 0);
                chk("rst_busy", busy, 0);
            end
            for (int i = 0; i < lens[l]; i++) begin
                href = 1;
                px_data = bytes[l][i];
                @(negedge clk);
            end
            href = 0;
            px_data = 8'($urandom);
            repeat (2) @(negedge clk);
            if (flip) begin
                capture_en = 1;
                chk("busy_disabled", busy, 0);
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_addr", addr_in, 0);
        chk("reset_data", data_in, 0);
        chk("reset_regwrite", regwrite, 0);
        chk("reset_frame_done", frame_done, 0);
        chk("reset_busy", busy, 0);
        reset = 0;
        @(negedge clk);
        lens = '{8, 8, 8};        drive_frame(1, 0, -1, 1);
        lens = '{3, 8, 8, 5, 8};  drive_frame(1, 0, -1, 0);
        lens = '{12, 12, 12};     drive_frame(1, 0, -1, 0);
        lens = '{8, 8, 8};        drive_frame(0, 1, -1, 0);
        lens = '{8, 8, 8};        drive_frame(1, 0, -1, 0);
        lens = '{8, 2, 8, 8};     drive_frame(1, 0, 2, 0);
        lens = '{8, 8, 8};        drive_frame(1, 0, -1, 0);
        lens = '{6, 6};           drive_frame(1, 0, -1, 0);
        for (int f = 0; f < 6; f++) begin
            int n;
            n = $urandom_range(1, 6);
            lens = '{};
            for (int l = 0; l < n; l++) lens.push_back($urandom_range(0, 12));
            drive_frame(1, 0, -1, 0);
        end
        vsync = 1;
        repeat (4) @(negedge clk);
        chk("writes_outstanding", exp_q.size(), 0);
        chk("frame_done_outstanding", fd_exp, 0);
        chk("busy_end", busy, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
